// File: rtl/wb_pkg.sv
// Shared definitions for the wb_master_rt Wishbone classic master:
// FSM state encoding, default bus widths and counter widths.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 24;

    // Width of the retry counter and the backoff gap counter.
    localparam int WB_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2
    } wb_state_t;

    // Byte-select width derived from the data width.
    function automatic int wb_sel_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_master_rt_if.sv
// Wishbone classic bus bundle between the wb_master_rt master and the
// interconnect. The master modport drives the cycle; the slave modport
// returns data and terminations.
interface wb_master_rt_if
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
);

    localparam int SEL_W = wb_sel_width(DATA_W);

    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_o_dat;
    logic [SEL_W-1:0]  wb_sel;
    logic [DATA_W-1:0] wb_i_dat;
    logic              wb_ack;
    logic              wb_err;
    logic              wb_rty;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
        input  wb_i_dat, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
        output wb_i_dat, wb_ack, wb_err, wb_rty
    );

endinterface

// File: rtl/wb_down_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement and
// the count never wraps below zero.
module wb_down_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/wb_master_rt.sv
// wb_master_rt: Wishbone classic master between the CPU memory stage and
// the bus interconnect. Supports chained transfers (i_mem_next), bus-error
// reporting and bounded retry with an idle gap after each wb_rty.
// Optional watchdog that aborts silent cycles: define WB_MASTER_TIMEOUT_EN.
module wb_master_rt
    import wb_pkg::*;
#(
    parameter int DATA_W      = WB_DATA_W,
    parameter int ADDR_W      = WB_ADDR_W,
    parameter int SEL_W       = wb_sel_width(DATA_W),
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_GAP   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [SEL_W-1:0]  i_mem_sel,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic              i_mem_next,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_ack,
    output logic              o_mem_err,
    wb_master_rt_if.master    wb
);

    // Elaboration-time guards on the configuration.
    if ((DATA_W % 8) != 0 || SEL_W != DATA_W / 8) begin : g_bad_width
        $error("wb_master_rt: DATA_W must be a multiple of 8 and SEL_W = DATA_W/8");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15 || RETRY_GAP < 1 || RETRY_GAP > 15) begin : g_bad_retry
        $error("wb_master_rt: MAX_RETRY and RETRY_GAP must lie in 1..15");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("wb_master_rt: TIMEOUT_CYC must be at least 1");
    end

    localparam logic [WB_CNT_W-1:0] RETRY_LIM = WB_CNT_W'(MAX_RETRY);
    localparam logic [WB_CNT_W-1:0] GAP_LOAD  = WB_CNT_W'(RETRY_GAP);

    wb_state_t           r_state;
    logic                r_cyc;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [DATA_W-1:0]   r_wdat;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_mem_data;
    logic                r_mem_ack;
    logic                r_mem_err;
    logic [WB_CNT_W-1:0] r_retry;

    wb_state_t           w_state_nxt;
    logic                w_cyc_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_adr_nxt;
    logic [DATA_W-1:0]   w_wdat_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [DATA_W-1:0]   w_mem_data_nxt;
    logic                w_mem_ack_nxt;
    logic                w_mem_err_nxt;
    logic [WB_CNT_W-1:0] w_retry_nxt;

    logic                w_gap_load;
    logic                w_gap_dec;
    logic [WB_CNT_W-1:0] w_gap_cnt;
    logic                w_gap_zero;
    logic                w_gap_done;
    logic                w_term;
    logic                w_timeout;

    assign w_term = wb.wb_ack | wb.wb_err | wb.wb_rty;

    // Backoff gap: loaded on a retried wb_rty, counts down while idling.
    assign w_gap_dec  = (r_state == ST_BACKOFF) && !w_gap_zero;
    // The re-issue happens on the edge where the count steps from 1 to 0,
    // so cyc stays low for exactly RETRY_GAP cycles.
    assign w_gap_done = w_gap_zero || (w_gap_cnt == WB_CNT_W'(1));

    wb_down_counter #(
        .W (WB_CNT_W)
    ) u_gap_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_count    (w_gap_cnt),
        .o_zero     (w_gap_zero)
    );

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic            w_wd_load;
    logic            w_wd_dec;
    logic [WD_W-1:0] w_wd_cnt;
    logic            w_wd_zero;

    // Restart the watchdog whenever a fresh bus cycle begins: entry from
    // IDLE/BACKOFF or a chain step (the only BUS->BUS path with a termination).
    assign w_wd_load = (w_state_nxt == ST_BUS) && ((r_state != ST_BUS) || w_term);
    assign w_wd_dec  = (r_state == ST_BUS) && !w_term && !w_wd_zero;
    // Loaded with TIMEOUT_CYC-1 so the abort lands after TIMEOUT_CYC silent
    // bus cycles; any real termination in that cycle takes precedence.
    assign w_timeout = (r_state == ST_BUS) && !w_term && (w_wd_cnt == '0);

    wb_down_counter #(
        .W (WD_W)
    ) u_wd_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_wd_load),
        .i_load_val (WD_W'(TIMEOUT_CYC - 1)),
        .i_dec      (w_wd_dec),
        .o_count    (w_wd_cnt),
        .o_zero     (w_wd_zero)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/BUS/BACKOFF machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_we_nxt       = r_we;
        w_adr_nxt      = r_adr;
        w_wdat_nxt     = r_wdat;
        w_sel_nxt      = r_sel;
        w_mem_data_nxt = r_mem_data;
        w_mem_ack_nxt  = 1'b0;
        w_mem_err_nxt  = 1'b0;
        w_retry_nxt    = r_retry;
        w_gap_load     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_mem_req && !r_mem_ack) begin
                    w_adr_nxt   = i_mem_addr;
                    w_sel_nxt   = i_mem_sel;
                    w_we_nxt    = i_mem_we;
                    w_wdat_nxt  = i_mem_we ? i_mem_data : '0;
                    w_cyc_nxt   = 1'b1;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_BUS;
                end
            end

            ST_BUS: begin
                if (wb.wb_err || (wb.wb_rty && (r_retry >= RETRY_LIM)) || w_timeout) begin
                    // Failed transfer: report ack+err together, chain broken.
                    w_cyc_nxt      = 1'b0;
                    w_mem_ack_nxt  = 1'b1;
                    w_mem_err_nxt  = 1'b1;
                    w_mem_data_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (wb.wb_rty) begin
                    w_cyc_nxt   = 1'b0;
                    w_retry_nxt = r_retry + WB_CNT_W'(1);
                    w_gap_load  = 1'b1;
                    w_state_nxt = ST_BACKOFF;
                end else if (wb.wb_ack) begin
                    w_mem_ack_nxt  = 1'b1;
                    w_mem_data_nxt = r_we ? '0 : wb.wb_i_dat;
                    if (i_mem_next && i_mem_req) begin
                        // Chain: keep cyc/stb up and load the next transfer.
                        w_adr_nxt   = i_mem_addr;
                        w_sel_nxt   = i_mem_sel;
                        w_we_nxt    = i_mem_we;
                        w_wdat_nxt  = i_mem_we ? i_mem_data : '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_cyc_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_BACKOFF: begin
                if (w_gap_done) begin
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = ST_BUS;
                end
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered bus/CPU outputs; everything clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_wdat     <= '0;
            r_sel      <= '0;
            r_mem_data <= '0;
            r_mem_ack  <= 1'b0;
            r_mem_err  <= 1'b0;
            r_retry    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_we       <= w_we_nxt;
            r_adr      <= w_adr_nxt;
            r_wdat     <= w_wdat_nxt;
            r_sel      <= w_sel_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_mem_ack  <= w_mem_ack_nxt;
            r_mem_err  <= w_mem_err_nxt;
            r_retry    <= w_retry_nxt;
        end
    end

    assign wb.wb_cyc   = r_cyc;
    assign wb.wb_stb   = r_cyc;
    assign wb.wb_we    = r_we;
    assign wb.wb_adr   = r_adr;
    assign wb.wb_o_dat = r_wdat;
    assign wb.wb_sel   = r_sel;

    assign o_mem_data  = r_mem_data;
    assign o_mem_ack   = r_mem_ack;
    assign o_mem_err   = r_mem_err;

endmodule

// File: tb/tb_wb_master_rt.sv
// Directed testbench for wb_master_rt. Inputs change on the falling edge,
// outputs are checked on the falling edge; the slave side is scripted.
module tb_wb_master_rt;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int SW = DW / 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [SW-1:0] mem_sel;
    logic          mem_req;
    logic          mem_we;
    logic          mem_next;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    int n_checks = 0;
    int n_errors = 0;

    wb_master_rt_if #(.DATA_W(DW), .ADDR_W(AW)) wbif ();

    wb_master_rt #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .MAX_RETRY   (3),
        .RETRY_GAP   (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .i_mem_sel  (mem_sel),
        .i_mem_req  (mem_req),
        .i_mem_we   (mem_we),
        .i_mem_next (mem_next),
        .o_mem_data (mem_rdata),
        .o_mem_ack  (mem_ack),
        .o_mem_err  (mem_err),
        .wb         (wbif)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        mem_addr = '0; mem_data = '0; mem_sel = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_next = 1'b0;
        wbif.wb_i_dat = '0; wbif.wb_ack = 1'b0; wbif.wb_err = 1'b0; wbif.wb_rty = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rst_cyc: got %b want 0", wbif.wb_cyc); end
        n_checks++; if (wbif.wb_stb !== 1'b0) begin n_errors++; $display("FAIL rst_stb: got %b want 0", wbif.wb_stb); end
        n_checks++; if (mem_ack !== 1'b0 || mem_err !== 1'b0) begin n_errors++; $display("FAIL rst_ack_err: got %b%b want 00", mem_ack, mem_err); end
        n_checks++; if (mem_rdata !== 16'h0000) begin n_errors++; $display("FAIL rst_rdata: got %h want 0000", mem_rdata); end
        n_checks++; if (wbif.wb_adr !== 24'h0 || wbif.wb_we !== 1'b0) begin n_errors++; $display("FAIL rst_adr_we: got %h/%b want 000000/0", wbif.wb_adr, wbif.wb_we); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL idle_cyc: got %b want 0", wbif.wb_cyc); end
    endtask

    task automatic test_single_read();
        mem_addr = 24'h000100; mem_we = 1'b0; mem_sel = 2'b11; mem_data = 16'h7777; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        n_checks++; if (wbif.wb_cyc !== 1'b1 || wbif.wb_stb !== 1'b1) begin n_errors++; $display("FAIL rd_cycstb: got %b%b want 11", wbif.wb_cyc, wbif.wb_stb); end
        n_checks++; if (wbif.wb_adr !== 24'h000100) begin n_errors++; $display("FAIL rd_adr: got %h want 000100", wbif.wb_adr); end
        n_checks++; if (wbif.wb_we !== 1'b0 || wbif.wb_o_dat !== 16'h0000) begin n_errors++; $display("FAIL rd_we_dat: got %b/%h want 0/0000", wbif.wb_we, wbif.wb_o_dat); end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0 || wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL rd_wait: ack %b cyc %b want 0 1", mem_ack, wbif.wb_cyc); end
        wbif.wb_ack = 1'b1; wbif.wb_i_dat = 16'hBEEF;
        @(negedge clk);
        wbif.wb_ack = 1'b0;
        n_checks++; if (mem_ack !== 1'b1 || mem_err !== 1'b0) begin n_errors++; $display("FAIL rd_ack: got ack %b err %b want 1 0", mem_ack, mem_err); end
        n_checks++; if (mem_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL rd_data: got %h want beef", mem_rdata); end
        n_checks++; if (wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rd_cyc_drop: got %b want 0", wbif.wb_cyc); end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0) begin n_errors++; $display("FAIL rd_ack_pulse: got %b want 0", mem_ack); end
    endtask

    task automatic test_write();
        mem_addr = 24'h000200; mem_data = 16'h1234; mem_sel = 2'b01; mem_we = 1'b1; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0; mem_we = 1'b0;
        n_checks++; if (wbif.wb_o_dat !== 16'h1234) begin n_errors++; $display("FAIL wr_dat: got %h want 1234", wbif.wb_o_dat); end
        n_checks++; if (wbif.wb_sel !== 2'b01) begin n_errors++; $display("FAIL wr_sel: got %b want 01", wbif.wb_sel); end
        n_checks++; if (wbif.wb_we !== 1'b1 || wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL wr_we_cyc: got %b%b want 11", wbif.wb_we, wbif.wb_cyc); end
        wbif.wb_ack = 1'b1; wbif.wb_i_dat = 16'hFFFF;
        @(negedge clk);
        wbif.wb_ack = 1'b0;
        n_checks++; if (mem_ack !== 1'b1) begin n_errors++; $display("FAIL wr_ack: got %b want 1", mem_ack); end
        n_checks++; if (mem_rdata !== 16'h0000) begin n_errors++; $display("FAIL wr_rdata: got %h want 0000", mem_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_dat;
        mem_addr = 24'h000010; mem_we = 1'b0; mem_sel = 2'b11; mem_req = 1'b1;
        @(negedge clk);
        n_checks++; if (wbif.wb_adr !== 24'h000010 || wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL ch_first: adr %h cyc %b want 000010 1", wbif.wb_adr, wbif.wb_cyc); end
        for (int k = 0; k < 3; k++) begin
            exp_dat = 16'hA010 + 16'(k);
            wbif.wb_ack = 1'b1; wbif.wb_i_dat = exp_dat;
            mem_next = (k < 2); mem_req = (k < 2);
            mem_addr = 24'h000011 + 24'(k);
            @(negedge clk);
            n_checks++; if (mem_ack !== 1'b1 || mem_rdata !== exp_dat) begin n_errors++; $display("FAIL ch_ack%0d: ack %b data %h want 1 %h", k, mem_ack, mem_rdata, exp_dat); end
            if (k < 2) begin
                exp_adr = 24'h000011 + 24'(k);
                n_checks++; if (wbif.wb_cyc !== 1'b1 || wbif.wb_adr !== exp_adr) begin n_errors++; $display("FAIL ch_step%0d: cyc %b adr %h want 1 %h", k, wbif.wb_cyc, wbif.wb_adr, exp_adr); end
            end else begin
                n_checks++; if (wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL ch_end: cyc %b want 0", wbif.wb_cyc); end
            end
        end
        wbif.wb_ack = 1'b0; mem_next = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0) begin n_errors++; $display("FAIL ch_after: ack %b want 0", mem_ack); end
    endtask

    task automatic test_retry();
        mem_addr = 24'h000300; mem_we = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        n_checks++; if (wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL rty_issue: cyc %b want 1", wbif.wb_cyc); end
        wbif.wb_rty = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wbif.wb_rty = 1'b0;
            n_checks++; if (wbif.wb_cyc !== 1'b0 || mem_ack !== 1'b0) begin n_errors++; $display("FAIL rty_gap1_%0d: cyc %b ack %b want 0 0", k, wbif.wb_cyc, mem_ack); end
            mem_req = 1'b1; mem_addr = 24'h000999;
            @(negedge clk);
            mem_req = 1'b0;
            n_checks++; if (wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rty_gap2_%0d: cyc %b want 0", k, wbif.wb_cyc); end
            @(negedge clk);
            n_checks++; if (wbif.wb_cyc !== 1'b1 || wbif.wb_adr !== 24'h000300) begin n_errors++; $display("FAIL rty_reissue%0d: cyc %b adr %h want 1 000300", k, wbif.wb_cyc, wbif.wb_adr); end
            if (k == 0) wbif.wb_rty = 1'b1;
            else begin wbif.wb_ack = 1'b1; wbif.wb_i_dat = 16'h5A5A; end
        end
        @(negedge clk);
        wbif.wb_ack = 1'b0;
        n_checks++; if (mem_ack !== 1'b1 || mem_err !== 1'b0) begin n_errors++; $display("FAIL rty_final: ack %b err %b want 1 0", mem_ack, mem_err); end
        n_checks++; if (mem_rdata !== 16'h5A5A || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rty_data: data %h cyc %b want 5a5a 0", mem_rdata, wbif.wb_cyc); end
        @(negedge clk);
    endtask

    task automatic test_err_with_ack();
        mem_addr = 24'h000500; mem_we = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        n_checks++; if (wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL err_issue: cyc %b want 1", wbif.wb_cyc); end
        wbif.wb_ack = 1'b1; wbif.wb_err = 1'b1; wbif.wb_i_dat = 16'h1111;
        mem_next = 1'b1; mem_req = 1'b1; mem_addr = 24'h000501;
        @(negedge clk);
        wbif.wb_ack = 1'b0; wbif.wb_err = 1'b0; mem_next = 1'b0; mem_req = 1'b0;
        n_checks++; if (mem_ack !== 1'b1 || mem_err !== 1'b1) begin n_errors++; $display("FAIL err_pulse: ack %b err %b want 1 1", mem_ack, mem_err); end
        n_checks++; if (mem_rdata !== 16'h0000 || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL err_data_cyc: data %h cyc %b want 0000 0", mem_rdata, wbif.wb_cyc); end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0 || mem_err !== 1'b0 || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL err_after: ack %b err %b cyc %b want 0 0 0", mem_ack, mem_err, wbif.wb_cyc); end
    endtask

    task automatic test_retry_exhaust();
        mem_addr = 24'h000400; mem_we = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (wbif.wb_cyc !== 1'b1 || wbif.wb_adr !== 24'h000400) begin n_errors++; $display("FAIL rtyx_try%0d: cyc %b adr %h want 1 000400", k, wbif.wb_cyc, wbif.wb_adr); end
            wbif.wb_rty = 1'b1; wbif.wb_i_dat = 16'h3C3C;
            @(negedge clk);
            wbif.wb_rty = 1'b0;
            if (k < 3) begin
                n_checks++; if (mem_ack !== 1'b0 || mem_err !== 1'b0 || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rtyx_gap%0d: ack %b err %b cyc %b want 0 0 0", k, mem_ack, mem_err, wbif.wb_cyc); end
                @(negedge clk);
                @(negedge clk);
            end
        end
        n_checks++; if (mem_ack !== 1'b1 || mem_err !== 1'b1) begin n_errors++; $display("FAIL rtyx_fail: ack %b err %b want 1 1", mem_ack, mem_err); end
        n_checks++; if (mem_rdata !== 16'h0000 || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL rtyx_data: data %h cyc %b want 0000 0", mem_rdata, wbif.wb_cyc); end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0 || mem_err !== 1'b0) begin n_errors++; $display("FAIL rtyx_pulse: ack %b err %b want 0 0", mem_ack, mem_err); end
    endtask

    task automatic test_reset_mid();
        mem_addr = 24'h000600; mem_we = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        n_checks++; if (wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL rstm_issue: cyc %b want 1", wbif.wb_cyc); end
        wbif.wb_ack = 1'b1; wbif.wb_i_dat = 16'hCAFE;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (wbif.wb_cyc !== 1'b0 || wbif.wb_stb !== 1'b0) begin n_errors++; $display("FAIL rstm_async: cyc %b stb %b want 0 0", wbif.wb_cyc, wbif.wb_stb); end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b0 || mem_err !== 1'b0 || mem_rdata !== 16'h0000) begin n_errors++; $display("FAIL rstm_outs: ack %b err %b data %h want 0 0 0000", mem_ack, mem_err, mem_rdata); end
        wbif.wb_ack = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (wbif.wb_cyc !== 1'b0 || mem_ack !== 1'b0) begin n_errors++; $display("FAIL rstm_idle: cyc %b ack %b want 0 0", wbif.wb_cyc, mem_ack); end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        mem_addr = 24'h000700; mem_we = 1'b0; mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        n_checks++; if (wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL wd_issue: cyc %b want 1", wbif.wb_cyc); end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            n_checks++; if (mem_ack !== 1'b0 || wbif.wb_cyc !== 1'b1) begin n_errors++; $display("FAIL wd_wait%0d: ack %b cyc %b want 0 1", k, mem_ack, wbif.wb_cyc); end
        end
        @(negedge clk);
        n_checks++; if (mem_ack !== 1'b1 || mem_err !== 1'b1 || wbif.wb_cyc !== 1'b0) begin n_errors++; $display("FAIL wd_abort: ack %b err %b cyc %b want 1 1 0", mem_ack, mem_err, wbif.wb_cyc); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_retry();
        test_err_with_ack();
        test_retry_exhaust();
        test_reset_mid();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_master_rt.md
Name: wb_master_rt

Overview:
- Parametrised, next-generation Wishbone classic master bridging the CPU memory port to the system bus.
- Generalises data/address width and byte selects.
- Adds back-to-back chaining via i_mem_next.
- Adds real bus-error reporting and bounded automatic retry on wb_rty; an optional watchdog aborts hung cycles.
- Sits between the CPU memory stage and the bus interconnect.

Parameters:
- DATA_W, 16: bus and CPU data width; must be a multiple of 8.
- ADDR_W, 24: bus address width.
- SEL_W, DATA_W/8: byte-select width; derived, do not override.
- MAX_RETRY, 3: number of wb_rty re-issues allowed per transfer before reporting an error; range 1..15.
- RETRY_GAP, 2: idle cycles (cyc low) between a wb_rty and the re-issue; range 1..15.
- TIMEOUT_CYC, 255: watchdog limit in cycles; used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_mem_addr  in  ADDR_W  CPU address
- i_mem_data  in  DATA_W  CPU write data
- i_mem_sel  in  SEL_W  CPU byte enables
- i_mem_req  in  1  CPU request
- i_mem_we  in  1  write enable
- i_mem_next  in  1  chain the next transfer without dropping cyc
- o_mem_data  out  DATA_W  read data
- o_mem_ack  out  1  one-cycle completion pulse
- o_mem_err  out  1  one-cycle pulse, coincident with o_mem_ack, on failed transfer
- wb_cyc, wb_stb, wb_we  out  1 each
- wb_adr  out  ADDR_W
- wb_o_dat  out  DATA_W
- wb_sel  out  SEL_W
- wb_i_dat  in  DATA_W
- wb_ack, wb_err, wb_rty  in  1 each

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low. While i_rst_n is low:
  - all outputs are 0; state is IDLE; retry, gap and watchdog counters are 0.
  - Reset mid-cycle drops cyc/stb immediately, with no ack or err.
- States: IDLE, BUS, BACKOFF.
- IDLE:
  - Accepts when i_mem_req=1 and o_mem_ack=0.
  - On accept, latches addr, sel, we and data into wb_adr, wb_sel, wb_we and wb_o_dat; wb_o_dat = 0 for reads.
  - Sets cyc=stb=1 from the next cycle and clears the retry count. Goes to BUS.
  - Latency: request at edge N, stb visible after N; an ack sampled at N+1 gives o_mem_ack after N+1.
- BUS terminations are sampled on the clock edge. Priority is wb_err > wb_rty > wb_ack.
- wb_ack:
  - o_mem_data = wb_we ? 0 : wb_i_dat; o_mem_ack pulses.
  - If i_mem_next & i_mem_req in the same cycle: cyc and stb stay high; new addr/sel/we/data are latched; the retry count clears; stay in BUS (chained transfer).
  - Otherwise: cyc=stb=0, go to IDLE. The cycle after an ack cannot accept, because o_mem_ack=1.
- wb_err:
  - cyc=stb=0; o_mem_ack and o_mem_err pulse; o_mem_data = 0; go to IDLE.
  - A chain is broken even if i_mem_next=1.
- wb_rty with retry count < MAX_RETRY:
  - cyc=stb=0; increment the retry count; load the gap counter with RETRY_GAP; go to BACKOFF.
- wb_rty with retry count = MAX_RETRY:
  - handled exactly as wb_err.
- BACKOFF:
  - The gap counter decrements each cycle.
  - At 0: reassert cyc/stb with the unchanged latched transfer; go to BUS.
  - i_mem_req changes are ignored while in BACKOFF.
- o_mem_ack and o_mem_err are never high for more than one cycle. No ack is issued without a preceding bus termination, except under the watchdog.
- Counter widths: 4 bits for retry and gap; $clog2(TIMEOUT_CYC+1) for the watchdog.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- When defined:
  - The watchdog counts cycles in BUS with no termination and clears on any termination or chain step.
  - When it reaches TIMEOUT_CYC, the transfer is handled as wb_err.
  - A termination arriving in the same cycle wins over the timeout.
- When undefined: no counter exists, and BUS waits indefinitely.

Decomposition:
- Shared package wb_pkg holds:
  - the state enum (IDLE/BUS/BACKOFF);
  - default widths (WB_DATA_W=16, WB_ADDR_W=24);
  - the derived SEL_W expression;
  - the retry/gap counter width constant.
- One sub-module, wb_down_counter: a loadable down-counter with a zero flag. It is instantiated for the backoff gap and, under WB_MASTER_TIMEOUT_EN, for the watchdog.

Test Plan:
- Single read to 0x000100: slave acks after 1 wait cycle with wb_i_dat=0xBEEF → o_mem_data=0xBEEF, one ack pulse, cyc low the following cycle, o_mem_err=0.
- Write 0x1234 with sel=2'b01 → wb_o_dat=0x1234, wb_sel=01, wb_we=1; after ack, o_mem_data=0.
- Chained reads to 0x10, 0x11, 0x12 with i_mem_next=1 on each ack → cyc stays high across all three, wb_adr steps through 0x10, 0x11, 0x12, three ack pulses.
- wb_rty twice, then ack (MAX_RETRY=3, RETRY_GAP=2) → cyc low for 2 cycles after each rty, same address re-issued, single final ack, no err.
- wb_rty on 4 consecutive attempts → o_mem_ack and o_mem_err pulse together after the 4th rty; wb_err asserted together with wb_ack → error path taken.
- Reset and watchdog:
  - i_rst_n low mid-BUS → cyc, stb and ack drop immediately and asynchronously.
  - With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=8, a silent slave → err and ack after 8 cycles.
